// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the arbitrated multiplier block.
package mult_arb_pkg;

   localparam int unsigned OP_W   = 4;
   localparam int unsigned PROD_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first asserted request at or after ptr, wrapping.
module rr_pick #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDW  = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   logic [31:0]    pos_w;
   logic [IDW-1:0] pos;

   // Scan from ptr upward modulo NREQ and keep the first hit
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos_w = '0;
      pos   = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos_w = 32'(ptr) + 32'(k);
         if (pos_w >= NREQ) pos_w = pos_w - NREQ;
         pos = IDW'(pos_w);
         if (!any && req[pos]) begin
            any        = 1'b1;
            idx        = pos;
            grant[pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tt_um_wallace.sv
// 4x4 unsigned multiplier built as a carry-save (Wallace-style) reduction of
// the four partial products followed by one carry-propagate adder.
module tt_um_wallace (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   logic [7:0] pp0, pp1, pp2, pp3;
   logic [7:0] s1, m1, c1, s2, m2, c2;

   // Partial products aligned to their binary weight
   always_comb begin
      pp0 = {4'b0000, a & {4{b[0]}}};
      pp1 = {3'b000,  a & {4{b[1]}}, 1'b0};
      pp2 = {2'b00,   a & {4{b[2]}}, 2'b00};
      pp3 = {1'b0,    a & {4{b[3]}}, 3'b000};
   end

   // Two 3:2 compression layers, then the final add
   always_comb begin
      s1 = pp0 ^ pp1 ^ pp2;
      m1 = (pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2);
      c1 = {m1[6:0], 1'b0};
      s2 = s1 ^ c1 ^ pp3;
      m2 = (s1 & c1) | (s1 & pp3) | (c1 & pp3);
      c2 = {m2[6:0], 1'b0};
      p  = s2 + c2;
   end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one 4x4 multiplier between NREQ requesters.
// Each op: grant in IDLE, one CALC cycle, then RESP held until consumed.
// Optional per-requester accumulators are built when MULT_ARB_ACC_EN is defined.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned ACC_W = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [4*NREQ-1:0]        req_a,
   input  logic [4*NREQ-1:0]        req_b,
   input  logic [NREQ-1:0]          req_acc,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ACC_W-1:0]         rsp_data,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic                     busy
);

   localparam int unsigned IDW = $clog2(NREQ);

   state_t              state_q, state_d;
   logic [NREQ-1:0]     pick_grant;
   logic [IDW-1:0]      pick_idx;
   logic                pick_any;
   logic [IDW-1:0]      rr_ptr, ptr_next;
   logic                grant_fire;
   logic [OP_W-1:0]     sel_a, sel_b;
   logic                sel_acc;
   logic [OP_W-1:0]     op_a, op_b;
   logic [IDW-1:0]      op_id;
   logic [PROD_W-1:0]   prod;
   logic [ACC_W-1:0]    prod_ext;
   logic [ACC_W-1:0]    result;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // A grant is only issued from IDLE and never while reset is asserted
   assign grant_fire = (state_q == IDLE) && pick_any && !rst;

   // Select the winner's operands and mode bit with the one-hot grant
   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_acc = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_grant[i]) begin
            sel_a   = req_a[i*OP_W +: OP_W];
            sel_b   = req_b[i*OP_W +: OP_W];
            sel_acc = req_acc[i];
         end
      end
   end

   // Pointer moves to the requester after the winner, wrapping at NREQ
   always_comb begin
      ptr_next = pick_idx + IDW'(1);
      if (32'(pick_idx) == NREQ - 1) ptr_next = '0;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_any)  state_d = CALC;
         CALC:                   state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // FSM outputs; req_ready must be visible in the grant cycle itself
   always_comb begin
      req_ready = '0;
      rsp_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE:    if (grant_fire) req_ready = pick_grant;
         CALC:    busy = 1'b1;
         RESP: begin
            busy      = 1'b1;
            rsp_valid = 1'b1;
         end
         default: busy = 1'b1;
      endcase
   end

   // Capture the granted op, then latch its result at the end of CALC
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= '0;
         op_a     <= '0;
         op_b     <= '0;
         op_id    <= '0;
         rsp_data <= '0;
         rsp_id   <= '0;
      end else begin
         if (grant_fire) begin
            rr_ptr <= ptr_next;
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_id  <= pick_idx;
         end
         if (state_q == CALC) begin
            rsp_data <= result;
            rsp_id   <= op_id;
         end
      end
   end

   tt_um_wallace u_mul (
      .a (op_a),
      .b (op_b),
      .p (prod)
   );

   assign prod_ext = ACC_W'(prod);

`ifdef MULT_ARB_ACC_EN
   logic             op_acc;
   logic [ACC_W-1:0] acc_q [NREQ];

   // Accumulate mode adds onto the owner's running sum, wrapping at ACC_W
   always_comb begin
      result = prod_ext;
      if (op_acc) result = acc_q[op_id] + prod_ext;
   end

   // Mode bit follows the grant; the owner's accumulator follows the result
   always_ff @(posedge clk) begin
      if (rst) begin
         op_acc <= 1'b0;
         for (int i = 0; i < NREQ; i++) acc_q[i] <= '0;
      end else begin
         if (grant_fire)        op_acc       <= sel_acc;
         if (state_q == CALC)   acc_q[op_id] <= result;
      end
   end
`else
   logic unused_acc;

   // Without accumulators the mode bit has no effect
   assign unused_acc = sel_acc;
   assign result     = prod_ext;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: per-cycle comparison against a
// transaction-level model, directed scenarios with literal expectations,
// and a randomized phase. Accumulate scenario depends on MULT_ARB_ACC_EN.
module tb_mult_arbiter;

   localparam int unsigned NREQ  = 2;
   localparam int unsigned ACC_W = 12;
   localparam int unsigned IDW   = 1;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_ready;
   logic [4*NREQ-1:0]   req_a = '0;
   logic [4*NREQ-1:0]   req_b = '0;
   logic [NREQ-1:0]     req_acc = '0;
   logic                rsp_valid;
   logic                rsp_ready = 1'b1;
   logic [ACC_W-1:0]    rsp_data;
   logic [IDW-1:0]      rsp_id;
   logic                busy;

   mult_arbiter #(.NREQ(NREQ), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_acc   (req_acc),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      else
         passes++;
   endtask

   // Transaction-level model: 0 = waiting for a request, 1 = op in flight,
   // 2 = response being offered.
   int  m_phase = 0;
   int  m_ptr = 0, m_id = 0, m_a = 0, m_b = 0, m_rsp_id = 0, m_data = 0;
   bit  m_accb = 0;
   int  m_acc [NREQ];
   bit  model_ok = 0;
   bit  prev_rv = 0;

   int  gnt_id_q[$], gnt_cyc_q[$], rsp_start_q[$], rsp_data_q[$], rsp_id_q[$];

   function automatic int rr_win(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (ptr + k) % NREQ;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // Compare every cycle on the falling edge, log events, then advance the model
   always @(negedge clk) begin
      logic [NREQ-1:0] exp_ready;
      int w, res;
      exp_ready = '0;
      w = rr_win(req_valid, m_ptr);
      if (!rst && m_phase == 0 && w >= 0) exp_ready[w] = 1'b1;
      if (model_ok) begin
         chk("req_ready", 32'(req_ready), 32'(exp_ready));
         chk("busy",      32'(busy),      32'(m_phase != 0));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
         chk("rsp_data",  32'(rsp_data),  32'(m_data));
         chk("rsp_id",    32'(rsp_id),    32'(m_rsp_id));
      end
      for (int i = 0; i < NREQ; i++)
         if (!rst && req_valid[i] && req_ready[i]) begin
            gnt_id_q.push_back(i);
            gnt_cyc_q.push_back(cyc);
         end
      if (rsp_valid === 1'b1 && !prev_rv) rsp_start_q.push_back(cyc);
      prev_rv = (rsp_valid === 1'b1);
      if (rsp_valid === 1'b1 && rsp_ready) begin
         rsp_data_q.push_back(int'(rsp_data));
         rsp_id_q.push_back(int'(rsp_id));
      end
      if (rst) begin
         model_ok = 1;
         m_phase = 0; m_ptr = 0; m_data = 0; m_rsp_id = 0;
         for (int i = 0; i < NREQ; i++) m_acc[i] = 0;
      end else begin
         case (m_phase)
            0: if (w >= 0) begin
                  m_id    = w;
                  m_a     = int'(req_a[w*4 +: 4]);
                  m_b     = int'(req_b[w*4 +: 4]);
                  m_accb  = req_acc[w];
                  m_ptr   = (w + 1) % NREQ;
                  m_phase = 1;
               end
            1: begin
                  res = m_a * m_b;
`ifdef MULT_ARB_ACC_EN
                  if (m_accb) res = (m_acc[m_id] + res) % (1 << ACC_W);
                  m_acc[m_id] = res;
`endif
                  m_data   = res;
                  m_rsp_id = m_id;
                  m_phase  = 2;
               end
            default: if (rsp_ready) m_phase = 0;
         endcase
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic set_req(input int id, input int a, input int b, input bit acc);
      req_valid[id]      = 1'b1;
      req_a[id*4 +: 4]   = 4'(a);
      req_b[id*4 +: 4]   = 4'(b);
      req_acc[id]        = acc;
   endtask

   // Present a request, hold it until granted, then drop it
   task automatic do_op(input int id, input int a, input int b, input bit acc);
      int n0, t;
      n0 = gnt_id_q.size(); t = 0;
      set_req(id, a, b, acc);
      while (gnt_id_q.size() <= n0 && t < 50) begin tick(1); t++; end
      req_valid[id] = 1'b0;
      chk("granted", 32'(gnt_id_q.size() > n0), 32'd1);
   endtask

   task automatic wait_resp(input int n0);
      int t;
      t = 0;
      while (rsp_data_q.size() <= n0 && t < 50) begin tick(1); t++; end
      chk("resp_arrived", 32'(rsp_data_q.size() > n0), 32'd1);
   endtask

   initial begin
      int g0, r0, s0, exp_sum;

      do_reset();
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data",  32'(rsp_data),  32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);

      // Single op: 7 * 9 on requester 0
      g0 = gnt_id_q.size(); r0 = rsp_data_q.size(); s0 = rsp_start_q.size();
      do_op(0, 7, 9, 0);
      wait_resp(r0);
      chk("single_gnt_cnt", 32'(gnt_id_q.size() - g0), 32'd1);
      chk("single_gnt_id",  32'(gnt_id_q[g0]), 32'd0);
      chk("single_latency", 32'(rsp_start_q[s0] - gnt_cyc_q[g0]), 32'd2);
      chk("single_data",    32'(rsp_data_q[r0]), 32'd63);
      chk("single_id",      32'(rsp_id_q[r0]),   32'd0);

      // Contention with boundary operands: req0 = 15*15, req1 = 0*13
      do_reset();
      g0 = gnt_id_q.size(); r0 = rsp_data_q.size();
      set_req(0, 15, 15, 0);
      set_req(1, 0, 13, 0);
      for (int t = 0; t < 40 && gnt_id_q.size() < g0 + 4; t++) tick(1);
      req_valid = '0;
      chk("cont_gnt_cnt", 32'(gnt_id_q.size() - g0), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk("cont_order", 32'(gnt_id_q[g0+k]), 32'(k % 2));
         if (k > 0) chk("cont_spacing", 32'(gnt_cyc_q[g0+k] - gnt_cyc_q[g0+k-1]), 32'd3);
      end
      wait_resp(r0 + 3);
      chk("boundary_225", 32'(rsp_data_q[r0]),   32'd225);
      chk("boundary_0",   32'(rsp_data_q[r0+1]), 32'd0);

      // Backpressure: response held 10 cycles while requester 0 waits
      rsp_ready = 1'b0;
      r0 = rsp_data_q.size(); g0 = gnt_id_q.size();
      do_op(1, 5, 6, 0);
      for (int t = 0; t < 10 && rsp_valid !== 1'b1; t++) tick(1);
      set_req(0, 3, 4, 0);
      for (int k = 0; k < 10; k++) begin
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_data",  32'(rsp_data),  32'd30);
         chk("bp_id",    32'(rsp_id),    32'd1);
         chk("bp_ready", 32'(req_ready), 32'd0);
         tick(1);
      end
      rsp_ready = 1'b1;
      wait_resp(r0);
      for (int t = 0; t < 20 && gnt_id_q.size() < g0 + 2; t++) tick(1);
      req_valid = '0;
      wait_resp(r0 + 1);
      chk("bp_done_data", 32'(rsp_data_q[r0]),   32'd30);
      chk("bp_next_data", 32'(rsp_data_q[r0+1]), 32'd12);
      chk("bp_next_id",   32'(gnt_id_q[g0+1]),   32'd0);

      // Reset in CALC: op is dropped, pointer returns to requester 0
      tick(2);
      s0 = rsp_start_q.size(); g0 = gnt_id_q.size();
      do_op(0, 2, 2, 0);
      rst = 1'b1; tick(1); rst = 1'b0;
      tick(5);
      chk("abort_no_rsp", 32'(rsp_start_q.size() - s0), 32'd0);
      set_req(0, 1, 1, 0);
      set_req(1, 1, 1, 0);
      for (int t = 0; t < 10 && gnt_id_q.size() < g0 + 2; t++) tick(1);
      req_valid = '0;
      chk("abort_next_gnt", 32'(gnt_id_q[g0+1]), 32'd0);
      tick(4);

      // Accumulate mode on requester 1
      do_reset();
      r0 = rsp_data_q.size();
`ifdef MULT_ARB_ACC_EN
      for (int k = 1; k <= 19; k++) begin
         do_op(1, 15, 15, (k > 1));
         wait_resp(r0 + k - 1);
         exp_sum = (k * 225) % 4096;
         chk("acc_sum", 32'(rsp_data_q[r0+k-1]), 32'(exp_sum));
      end
      chk("acc_wrap", 32'(rsp_data_q[r0+18]), 32'd179);
`else
      for (int k = 1; k <= 2; k++) begin
         do_op(1, 15, 15, 1'b1);
         wait_resp(r0 + k - 1);
         chk("acc_ignored", 32'(rsp_data_q[r0+k-1]), 32'd225);
      end
`endif

      // Randomized traffic, backpressure and occasional reset
      for (int t = 0; t < 800; t++) begin
         req_valid = NREQ'($urandom);
         req_a     = (4*NREQ)'($urandom);
         req_b     = (4*NREQ)'($urandom);
         req_acc   = NREQ'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 63) == 0);
         tick(1);
      end
      rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
      tick(5);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
